output_scorer: RTL and testbench

OUTPUT_SCORER -- requirements
Module: output_scorer

---
 rtl/output_scorer_pkg.sv | 17 +
 rtl/output_scorer_if.sv | 50 +++++
 rtl/output_scorer_argmax_tracker.sv | 65 ++++++
 rtl/output_scorer.sv | 156 +++++++++++++++
 tb/tb_output_scorer.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/output_scorer_pkg.sv
// ----------------------------------------------------------------------------
// output_scorer_pkg
// Shared definitions for the output scorer block: FSM state encoding and the
// widths of the run counters and class labels.
// ----------------------------------------------------------------------------
package output_scorer_pkg;

    localparam int CNT_W   = 16;  // width of correct_cnt / test_cnt
    localparam int LABEL_W = 4;   // width of label / pred_idx / max_idx

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,  // waiting for the first neuron of a vector
        ST_COLLECT = 2'd1,  // accumulating the argmax of the current vector
        ST_DONE    = 2'd2   // all test vectors scored; inputs ignored
    } state_t;

endpackage : output_scorer_pkg

// File: rtl/output_scorer_if.sv
// ----------------------------------------------------------------------------
// output_scorer_if
// Bundles the controller-side inputs and the scoring results of the output
// scorer.
//   master : controller / testbench side (drives neurons, label, commit, clr)
//   slave  : output_scorer side (drives prediction, counters, flags)
// Signals:
//   clr          synchronous clear of the run
//   neuron_valid neuron_val carries the next output-neuron value
//   neuron_val   signed output-neuron activation (DW bits)
//   label        expected class of the current vector
//   commit       end of current vector
//   pred_valid   one-cycle pulse, pred_idx/hit valid
//   pred_idx     argmax index of the committed vector
//   hit          pred_idx matched label
//   correct_cnt  hits in the current run
//   test_cnt     accepted commits in the current run
//   error        sticky protocol-violation flag
//   done         run complete
// ----------------------------------------------------------------------------
interface output_scorer_if #(
    parameter int DW = 16
);
    import output_scorer_pkg::*;

    logic                      clr;
    logic                      neuron_valid;
    logic signed [DW-1:0]      neuron_val;
    logic        [LABEL_W-1:0] label;
    logic                      commit;

    logic                      pred_valid;
    logic        [LABEL_W-1:0] pred_idx;
    logic                      hit;
    logic        [CNT_W-1:0]   correct_cnt;
    logic        [CNT_W-1:0]   test_cnt;
    logic                      error;
    logic                      done;

    modport master (
        output clr, neuron_valid, neuron_val, label, commit,
        input  pred_valid, pred_idx, hit, correct_cnt, test_cnt, error, done
    );

    modport slave (
        input  clr, neuron_valid, neuron_val, label, commit,
        output pred_valid, pred_idx, hit, correct_cnt, test_cnt, error, done
    );

endinterface : output_scorer_if

// File: rtl/output_scorer_argmax_tracker.sv
// ----------------------------------------------------------------------------
// argmax_tracker
// Holds the running maximum, its index and the index of the next expected
// neuron for one test vector.
// Ports:
//   clk, rst    clock / asynchronous active-high reset
//   i_clear     synchronous clear of all tracked state
//   i_load      take i_val as the first neuron (index 0)
//   i_update    compare i_val (at index o_idx) against the running max
//   i_val       signed neuron value
//   o_max_idx   index of the running maximum
//   o_full      all N_OUT neurons of the vector have been seen
// ----------------------------------------------------------------------------
module argmax_tracker
    import output_scorer_pkg::*;
#(
    parameter int DW    = 16,
    parameter int N_OUT = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_clear,
    input  logic                      i_load,
    input  logic                      i_update,
    input  logic signed [DW-1:0]      i_val,
    output logic        [LABEL_W-1:0] o_max_idx,
    output logic                      o_full
);

    // idx must be able to reach N_OUT itself (the "vector full" value).
    localparam int IDX_W = $clog2(N_OUT + 1);

    logic signed [DW-1:0]      r_max;
    logic        [LABEL_W-1:0] r_max_idx;
    logic        [IDX_W-1:0]   r_idx;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_max     <= '0;
            r_max_idx <= '0;
            r_idx     <= '0;
        end else if (i_clear) begin
            r_max     <= '0;
            r_max_idx <= '0;
            r_idx     <= '0;
        end else if (i_load) begin
            r_max     <= i_val;
            r_max_idx <= '0;
            r_idx     <= IDX_W'(1);
        end else if (i_update) begin
            // Strictly greater: ties keep the earlier (lower) index.
            if (i_val > r_max) begin
                r_max     <= i_val;
                r_max_idx <= LABEL_W'(r_idx);
            end
            r_idx <= r_idx + IDX_W'(1);
        end
    end

    assign o_max_idx = r_max_idx;
    assign o_full    = (r_idx == IDX_W'(N_OUT));

endmodule : argmax_tracker

// File: rtl/output_scorer.sv
// ----------------------------------------------------------------------------
// output_scorer
// Scores a run of N_TESTS test vectors: for each vector of N_OUT signed
// output-neuron values it finds the argmax, compares it with the label on
// commit, and keeps hit / test counters plus a sticky protocol-error flag.
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous active-high reset
//   bus   output_scorer_if.slave (inputs, prediction, counters, flags)
// ----------------------------------------------------------------------------
module output_scorer
    import output_scorer_pkg::*;
#(
    parameter int DW      = 16,
    parameter int N_OUT   = 10,
    parameter int N_TESTS = 750
) (
    input  logic              clk,
    input  logic              rst,
    output_scorer_if.slave    bus
);

    state_t r_state, w_state_next;

    logic                 w_load;
    logic                 w_update;
    logic                 w_trk_clear;
    logic                 w_accept;
    logic                 w_err_set;
    logic [LABEL_W-1:0]   w_max_idx;
    logic                 w_full;
    logic                 w_hit;
    logic [CNT_W-1:0]     w_test_cnt_next;

    logic                 r_pred_valid;
    logic [LABEL_W-1:0]   r_pred_idx;
    logic                 r_hit;
    logic [CNT_W-1:0]     r_correct_cnt;
    logic [CNT_W-1:0]     r_test_cnt;
    logic                 r_error;

    argmax_tracker #(
        .DW    (DW),
        .N_OUT (N_OUT)
    ) u_argmax (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_trk_clear),
        .i_load    (w_load),
        .i_update  (w_update),
        .i_val     (bus.neuron_val),
        .o_max_idx (w_max_idx),
        .o_full    (w_full)
    );

    assign w_hit           = (w_max_idx == bus.label);
    assign w_test_cnt_next = r_test_cnt + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // NOTE: every always_comb output gets a default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_update     = 1'b0;
        w_trk_clear  = 1'b0;
        w_accept     = 1'b0;
        w_err_set    = 1'b0;

        if (bus.clr) begin
            w_state_next = ST_IDLE;
            w_trk_clear  = 1'b1;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.commit) begin
                        // Commit with no vector collected; any same-cycle
                        // neuron is dropped as well.
                        w_err_set   = 1'b1;
                        w_trk_clear = 1'b1;
                    end else if (bus.neuron_valid) begin
                        w_load       = 1'b1;
                        w_state_next = ST_COLLECT;
                    end
                end

                ST_COLLECT: begin
                    if (bus.commit) begin
                        w_trk_clear = 1'b1;
                        if (bus.neuron_valid) w_err_set = 1'b1;
                        if (w_full) begin
                            w_accept     = 1'b1;
                            w_state_next = (w_test_cnt_next == CNT_W'(N_TESTS))
                                           ? ST_DONE : ST_IDLE;
                        end else begin
                            w_err_set    = 1'b1;
                            w_state_next = ST_IDLE;
                        end
                    end else if (bus.neuron_valid) begin
                        if (w_full) w_err_set = 1'b1;
                        else        w_update  = 1'b1;
                    end
                end

                ST_DONE: begin
                    // Run complete: inputs ignored until clr or rst.
                end

                default: begin
                    w_state_next = ST_IDLE;
                    w_trk_clear  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pred_valid  <= 1'b0;
            r_pred_idx    <= '0;
            r_hit         <= 1'b0;
            r_correct_cnt <= '0;
            r_test_cnt    <= '0;
            r_error       <= 1'b0;
        end else if (bus.clr) begin
            r_pred_valid  <= 1'b0;
            r_pred_idx    <= '0;
            r_hit         <= 1'b0;
            r_correct_cnt <= '0;
            r_test_cnt    <= '0;
            r_error       <= 1'b0;
        end else begin
            r_pred_valid <= w_accept;
            if (w_accept) begin
                r_pred_idx <= w_max_idx;
                r_hit      <= w_hit;
                r_test_cnt <= w_test_cnt_next;
                if (w_hit) r_correct_cnt <= r_correct_cnt + CNT_W'(1);
            end
            if (w_err_set) r_error <= 1'b1;
        end
    end

    assign bus.pred_valid  = r_pred_valid;
    assign bus.pred_idx    = r_pred_idx;
    assign bus.hit         = r_hit;
    assign bus.correct_cnt = r_correct_cnt;
    assign bus.test_cnt    = r_test_cnt;
    assign bus.error       = r_error;
    assign bus.done        = (r_state == ST_DONE);

endmodule : output_scorer

// File: tb/tb_output_scorer.sv
// ----------------------------------------------------------------------------
// tb_output_scorer
// Directed bench for output_scorer with N_OUT=10, N_TESTS=3. Inputs change on
// the falling edge; outputs are sampled on the falling edge (half a cycle
// after the rising edge that updated them).
// ----------------------------------------------------------------------------
module tb_output_scorer;

    localparam int DW      = 16;
    localparam int N_OUT   = 10;
    localparam int N_TESTS = 3;

    logic clk;
    logic rst;

    int n_checks;
    int n_bad;

    output_scorer_if #(.DW(DW)) bus ();

    output_scorer #(
        .DW      (DW),
        .N_OUT   (N_OUT),
        .N_TESTS (N_TESTS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vec_a [N_OUT] = '{3, -7, 12, 5, 12, 0, 1, 2, -1, 4};          // argmax 2
    int vec_b [N_OUT] = '{-100, -99, -98, -97, -96, -95, -94, -93, -92, -91}; // argmax 9
    int vec_c [N_OUT] = '{0, 1, 2, 3, 50, -5, 6, 50, 7, 8};            // tie -> 4

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drives one neuron for a single cycle, starting and ending on a negedge.
    task automatic send_neuron(input int v);
        bus.neuron_valid = 1'b1;
        bus.neuron_val   = DW'(v);
        @(negedge clk);
        bus.neuron_valid = 1'b0;
        bus.neuron_val   = '0;
    endtask

    task automatic send_commit(input int lbl);
        bus.commit = 1'b1;
        bus.label  = 4'(lbl);
        @(negedge clk);
        bus.commit = 1'b0;
    endtask

    task automatic send_vec_a();
        for (int i = 0; i < N_OUT; i++) send_neuron(vec_a[i]);
    endtask

    task automatic check_outputs(input string tag, input int pv, input int pidx,
                                 input int h, input int corr, input int tcnt,
                                 input int err, input int dn);
        check({tag, ".pred_valid"},  int'(bus.pred_valid),  pv);
        check({tag, ".pred_idx"},    int'(bus.pred_idx),    pidx);
        check({tag, ".hit"},         int'(bus.hit),         h);
        check({tag, ".correct_cnt"}, int'(bus.correct_cnt), corr);
        check({tag, ".test_cnt"},    int'(bus.test_cnt),    tcnt);
        check({tag, ".error"},       int'(bus.error),       err);
        check({tag, ".done"},        int'(bus.done),        dn);
    endtask

    initial begin
        n_checks         = 0;
        n_bad            = 0;
        rst              = 1'b1;
        bus.clr          = 1'b0;
        bus.neuron_valid = 1'b0;
        bus.neuron_val   = '0;
        bus.label        = '0;
        bus.commit       = 1'b0;

        repeat (3) @(negedge clk);
        check_outputs("reset", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);

        // Vector A plus an 11th neuron that would win if not discarded.
        send_vec_a();
        send_neuron(100);
        check("overflow.error", int'(bus.error), 1);
        send_commit(2);
        check_outputs("vecA_ovf", 1, 2, 1, 1, 1, 1, 0);
        @(negedge clk);
        check("vecA_ovf.pulse_end", int'(bus.pred_valid), 0);

        // Asynchronous reset mid-vector: outputs clear before any clock edge.
        for (int i = 0; i < 5; i++) send_neuron(vec_b[i]);
        #1 rst = 1'b1;
        #1;
        check_outputs("async_rst", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Fresh vector after reset must be scored from index 0 without error.
        send_vec_a();
        send_commit(2);
        check_outputs("after_rst", 1, 2, 1, 1, 1, 0, 0);

        // Synchronous clear mid-vector.
        for (int i = 0; i < 5; i++) send_neuron(vec_c[i]);
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        check_outputs("clr", 0, 0, 0, 0, 0, 0, 0);

        send_vec_a();
        send_commit(2);
        check_outputs("vecA", 1, 2, 1, 1, 1, 0, 0);

        // All-negative vector, wrong label.
        for (int i = 0; i < N_OUT; i++) send_neuron(vec_b[i]);
        send_commit(0);
        check_outputs("vecB", 1, 9, 0, 1, 2, 0, 0);

        // Short vector: commit after 7 neurons is rejected.
        for (int i = 0; i < 7; i++) send_neuron(vec_a[i]);
        send_commit(2);
        check_outputs("short", 0, 9, 0, 1, 2, 1, 0);

        // Full vector with a tie between indices 4 and 7; third accepted commit.
        for (int i = 0; i < N_OUT; i++) send_neuron(vec_c[i]);
        send_commit(4);
        check_outputs("vecC_tie", 1, 4, 1, 2, 3, 1, 1);

        // Run is done: further vectors and commits are ignored.
        send_vec_a();
        send_commit(2);
        check_outputs("after_done", 0, 4, 1, 2, 3, 1, 1);
        @(negedge clk);
        check("after_done.hold", int'(bus.test_cnt), 3);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    // Safety net so the bench can never hang.
    initial begin
        #100000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "simulation time limit reached");
    end

endmodule : tb_output_scorer
